// File: rtl/tone_meter.sv
// tone_meter: measures the half-period of an external square wave and reports
// it as a tonegen divider value. Writing dat_do to tonegen reproduces the
// measured tone. A value of 0 means silence.
//
// Ports:
//   clk       system clock
//   resetn    asynchronous active-low reset
//   tone_in   external square wave, asynchronous to clk
//   dat_re    read-acknowledge pulse; clears dat_valid and dat_ovr
//   dat_do    latest divider value (0 = silence / no measurement)
//   dat_valid new value not yet acknowledged
//   dat_ovr   a new value overwrote an unacknowledged one
//   locked    at least one accepted measurement since last silence or glitch
module tone_meter #(
  parameter int WIDTH    = 32,
  parameter int MIN_HALF = 4,
  parameter int TIMEOUT  = 16000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tone_in,
  input  logic             dat_re,
  output logic [WIDTH-1:0] dat_do,
  output logic             dat_valid,
  output logic             dat_ovr,
  output logic             locked
);

  localparam logic [WIDTH-1:0] MIN_H = WIDTH'(MIN_HALF);
  localparam logic [WIDTH-1:0] TMO   = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  state_t           state, state_d;
  logic             sync1, sync2, prev;
  logic             tone_edge;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic             cap;
  logic [WIDTH-1:0] cap_val;
  logic             lock_set, lock_clr;

  // Two-flop synchronizer plus one history flop; either polarity is an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign tone_edge = sync2 ^ prev;

  // Next-state / capture decode. An edge takes priority over the timeout, so
  // an edge landing exactly at cnt == TIMEOUT is captured as a measurement.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cap      = 1'b0;
    cap_val  = '0;
    lock_set = 1'b0;
    lock_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (tone_edge) begin
          state_d = ARMED;
          cnt_d   = WIDTH'(1);
        end
      end
      ARMED, LOCKED: begin
        if (tone_edge) begin
          cnt_d = WIDTH'(1);
          if (cnt >= MIN_H) begin
            // tonegen toggles every divider+2 cycles
            cap      = 1'b1;
            cap_val  = cnt - WIDTH'(2);
            state_d  = LOCKED;
            lock_set = 1'b1;
          end else begin
            state_d  = ARMED;
            lock_clr = 1'b1;
          end
        end else begin
          cnt_d = cnt + WIDTH'(1);
          if (cnt == TMO) begin
            cap      = 1'b1;
            cap_val  = '0;
            state_d  = IDLE;
            lock_clr = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Output register. A capture beats a simultaneous read: the read then
  // neither clears the flags nor counts as losing data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dat_do    <= '0;
      dat_valid <= 1'b0;
      dat_ovr   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      if (cap) begin
        dat_do    <= cap_val;
        dat_valid <= 1'b1;
        if (!dat_re && dat_valid) dat_ovr <= 1'b1;
      end else if (dat_re) begin
        dat_valid <= 1'b0;
        dat_ovr   <= 1'b0;
      end
      if (lock_set)      locked <= 1'b1;
      else if (lock_clr) locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_meter.sv
module tb_tone_meter;
  localparam int W   = 32;
  localparam int MH  = 4;
  localparam int TMO = 400;

  logic         clk = 1'b0;
  logic         resetn;
  logic         tone_in;
  logic         dat_re;
  logic [W-1:0] dat_do;
  logic         dat_valid, dat_ovr, locked;

  int pass_cnt = 0;
  int total    = 0;

  tone_meter #(.WIDTH(W), .MIN_HALF(MH), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .tone_in(tone_in), .dat_re(dat_re),
    .dat_do(dat_do), .dat_valid(dat_valid), .dat_ovr(dat_ovr), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          gap;   // cycles from this toggle to the next one
    bit          re;    // acknowledge after checking
    logic [31:0] edo;
    logic        ev, eo, el;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tog();
    tone_in = ~tone_in;
  endtask

  task automatic chk_all(input string nm, input logic [31:0] edo,
                         input logic ev, input logic eo, input logic el);
    chk({nm, ".do"},     dat_do,    edo);
    chk({nm, ".valid"},  dat_valid, {31'b0, ev});
    chk({nm, ".ovr"},    dat_ovr,   {31'b0, eo});
    chk({nm, ".locked"}, locked,    {31'b0, el});
  endtask

  task automatic ack();
    dat_re = 1'b1;
    cyc(1);
    dat_re = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    // tone period 102 (divider 100), change to a partial 150 then 302 (divider 300)
    vecs[0] = '{102, 0,   0, 0, 0, 0};  // first edge only arms
    vecs[1] = '{102, 0, 100, 1, 0, 1};
    vecs[2] = '{102, 1, 100, 1, 1, 1};  // overwrote unread value
    vecs[3] = '{102, 1, 100, 1, 0, 1};
    vecs[4] = '{150, 0, 100, 1, 0, 1};
    vecs[5] = '{302, 1, 148, 1, 1, 1};  // partial interval after divider change
    vecs[6] = '{302, 1, 300, 1, 0, 1};
    vecs[7] = '{102, 1, 300, 1, 0, 1};
    vecs[8] = '{102, 1, 100, 1, 0, 1};

    resetn = 1'b0; tone_in = 1'b0; dat_re = 1'b0;
    cyc(3);
    chk_all("reset", 0, 0, 0, 0);
    resetn = 1'b1;
    cyc(3);

    // edge reaches the capture register 3 cycles after the pin toggles
    foreach (vecs[i]) begin
      tog();
      cyc(3);
      chk_all($sformatf("vec%0d", i), vecs[i].edo, vecs[i].ev, vecs[i].eo, vecs[i].el);
      if (vecs[i].re) begin
        ack();
        chk($sformatf("vec%0d.ack_valid", i), dat_valid, 0);
        chk($sformatf("vec%0d.ack_ovr", i), dat_ovr, 0);
        cyc(vecs[i].gap - 4);
      end else begin
        cyc(vecs[i].gap - 3);
      end
    end

    // read coincident with capture, then read held for several cycles
    tog();
    cyc(2);
    dat_re = 1'b1;
    cyc(1);
    chk_all("coinc", 100, 1, 0, 1);
    cyc(2);
    dat_re = 1'b0;
    chk("held_re.valid", dat_valid, 0);
    cyc(97);

    // 2-cycle glitch right after a good edge
    tog();
    cyc(2);
    tog();
    cyc(1);
    chk_all("pre_glitch", 100, 1, 0, 1);
    cyc(2);
    chk_all("glitch", 100, 1, 0, 0);
    cyc(99);
    tog();
    cyc(3);
    chk_all("relock", 100, 1, 1, 1);
    ack();
    cyc(98);

    // silence: timeout fires exactly TMO cycles after the last edge, once
    tog();
    cyc(3);
    ack();
    cyc(TMO - 2);
    chk_all("pre_timeout", 100, 0, 0, 1);
    cyc(1);
    chk_all("timeout", 0, 1, 0, 0);
    ack();
    cyc(2 * TMO);
    chk_all("no_repeat", 0, 0, 0, 0);

    // from idle: first edge arms, second measures; then async reset mid-count
    tog();
    cyc(3);
    chk_all("idle_arm", 0, 0, 0, 0);
    cyc(99);
    tog();
    cyc(3);
    chk_all("idle_meas", 100, 1, 0, 1);
    cyc(20);
    resetn = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    tone_in = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(3);
    tog();
    cyc(3);
    chk_all("post_rst_arm", 0, 0, 0, 0);
    cyc(99);
    tog();
    cyc(3);
    chk_all("post_rst_meas", 100, 1, 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
